twi_line_filter: RTL and testbench

TWI_LINE_FILTER -- requirements
Module: twi_line_filter

---
 rtl/twi_line_filter.sv | 161 ++++++++++++++++
 tb/tb_twi_line_filter.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/twi_line_filter.sv
// twi_line_filter
// Conditions the raw SCL/SDA pins of a TWI slave: each line is synchronized,
// then debounced so a new level is only accepted after FILTER_LEN consecutive
// agreeing samples. From the clean lines it derives edge pulses, START/STOP
// detection, a bus-busy flag, a stuck-low SCL timeout and a saturating count
// of rejected glitches.

module twi_line_filter #(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 40000
) (
    input  logic       clk_16mhz,
    input  logic       rst,
    input  logic       scl_raw,
    input  logic       sda_raw,
    output logic       scl_clean,
    output logic       sda_clean,
    output logic       scl_rise,
    output logic       scl_fall,
    output logic       start_det,
    output logic       stop_det,
    output logic       bus_busy,
    output logic       bus_timeout,
    output logic [7:0] glitch_count
);

    localparam int TIMEOUT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [3:0] FILTER_MAX = 4'(FILTER_LEN - 1);
    localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_MAX = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

    logic [SYNC_STAGES-1:0]   scl_sync;
    logic [SYNC_STAGES-1:0]   sda_sync;
    logic                     scl_synced;
    logic                     sda_synced;
    logic [3:0]               scl_cnt;
    logic [3:0]               sda_cnt;
    logic                     scl_accept;
    logic                     sda_accept;
    logic                     scl_glitch;
    logic                     sda_glitch;
    logic                     start_hit;
    logic                     stop_hit;
    logic                     timeout_hit;
    logic [TIMEOUT_WIDTH-1:0] timeout_cnt;
    logic [1:0]               glitch_inc;
    logic [8:0]               glitch_sum;

    assign scl_synced = scl_sync[SYNC_STAGES-1];
    assign sda_synced = sda_sync[SYNC_STAGES-1];

    // A line is accepted on the cycle its disagreement run reaches full length;
    // a run that ends early (synced falls back to clean) counts as a glitch.
    assign scl_accept = (scl_synced != scl_clean) && (scl_cnt == FILTER_MAX);
    assign sda_accept = (sda_synced != sda_clean) && (sda_cnt == FILTER_MAX);
    assign scl_glitch = (scl_synced == scl_clean) && (scl_cnt != 4'd0);
    assign sda_glitch = (sda_synced == sda_clean) && (sda_cnt != 4'd0);

    // START/STOP only count when SCL stays high across the SDA change, so a
    // simultaneous change of both clean lines is never taken as a condition.
    assign start_hit = sda_accept && !sda_synced && scl_clean && !scl_accept;
    assign stop_hit  = sda_accept &&  sda_synced && scl_clean && !scl_accept;

    assign timeout_hit = bus_busy && !scl_clean && (timeout_cnt == TIMEOUT_MAX);

    assign glitch_inc = {1'b0, scl_glitch} + {1'b0, sda_glitch};
    assign glitch_sum = {1'b0, glitch_count} + {7'b0, glitch_inc};

    // Metastability chain per line; resets to the idle pulled-up level.
    always_ff @(posedge clk_16mhz or posedge rst) begin
        if (rst) begin
            scl_sync <= '1;
            sda_sync <= '1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_raw};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_raw};
        end
    end

    // SCL debounce: count disagreeing samples, switch clean after a full run.
    always_ff @(posedge clk_16mhz or posedge rst) begin
        if (rst) begin
            scl_cnt   <= 4'd0;
            scl_clean <= 1'b1;
        end else if (scl_synced == scl_clean) begin
            scl_cnt <= 4'd0;
        end else if (scl_accept) begin
            scl_cnt   <= 4'd0;
            scl_clean <= scl_synced;
        end else begin
            scl_cnt <= scl_cnt + 4'd1;
        end
    end

    // SDA debounce: same rule as SCL, independent counter.
    always_ff @(posedge clk_16mhz or posedge rst) begin
        if (rst) begin
            sda_cnt   <= 4'd0;
            sda_clean <= 1'b1;
        end else if (sda_synced == sda_clean) begin
            sda_cnt <= 4'd0;
        end else if (sda_accept) begin
            sda_cnt   <= 4'd0;
            sda_clean <= sda_synced;
        end else begin
            sda_cnt <= sda_cnt + 4'd1;
        end
    end

    // Edge and bus-condition pulses, registered alongside the clean update.
    always_ff @(posedge clk_16mhz or posedge rst) begin
        if (rst) begin
            scl_rise    <= 1'b0;
            scl_fall    <= 1'b0;
            start_det   <= 1'b0;
            stop_det    <= 1'b0;
            bus_timeout <= 1'b0;
        end else begin
            scl_rise    <= scl_accept &&  scl_synced;
            scl_fall    <= scl_accept && !scl_synced;
            start_det   <= start_hit;
            stop_det    <= stop_hit;
            bus_timeout <= timeout_hit;
        end
    end

    // Bus ownership: START wins (covers repeated START), STOP or timeout release.
    always_ff @(posedge clk_16mhz or posedge rst) begin
        if (rst) begin
            bus_busy <= 1'b0;
        end else if (start_hit) begin
            bus_busy <= 1'b1;
        end else if (stop_hit || timeout_hit) begin
            bus_busy <= 1'b0;
        end
    end

    // Stuck-low watchdog: runs only while busy with SCL low; firing drops busy
    // so it cannot fire again until a new START.
    always_ff @(posedge clk_16mhz or posedge rst) begin
        if (rst) begin
            timeout_cnt <= '0;
        end else if (!bus_busy || scl_clean || timeout_hit) begin
            timeout_cnt <= '0;
        end else begin
            timeout_cnt <= timeout_cnt + TIMEOUT_WIDTH'(1);
        end
    end

    // Rejected-pulse statistics, saturating at 255.
    always_ff @(posedge clk_16mhz or posedge rst) begin
        if (rst) begin
            glitch_count <= 8'd0;
        end else if (glitch_sum > 9'd255) begin
            glitch_count <= 8'd255;
        end else begin
            glitch_count <= glitch_sum[7:0];
        end
    end

endmodule

// File: tb/tb_twi_line_filter.sv
// tb_twi_line_filter
// Drives twi_line_filter with directed bus scenarios and random line noise and
// compares every output, every cycle, against a sample-history reference model.

`timescale 1ns/1ps

module tb_twi_line_filter;

    localparam int SYNC_STAGES    = 2;
    localparam int FILTER_LEN     = 4;
    localparam int TIMEOUT_CYCLES = 40000;
    localparam logic [15:0] FMASK = (16'd1 << FILTER_LEN) - 16'd1;
    localparam logic [31:0] RESET_VEC = 32'h0000C000;

    logic       clk_16mhz;
    logic       rst;
    logic       scl_raw;
    logic       sda_raw;
    logic       scl_clean;
    logic       sda_clean;
    logic       scl_rise;
    logic       scl_fall;
    logic       start_det;
    logic       stop_det;
    logic       bus_busy;
    logic       bus_timeout;
    logic [7:0] glitch_count;

    int vectors;
    int miscompares;
    int cycle;
    int n_rise;
    int n_fall;
    int n_start;
    int n_stop;
    int n_timeout;

    // Reference model state: raw samples in flight through the synchronizer,
    // recent synchronized samples per line, and the derived bus state.
    logic        m_scl_pipe[$];
    logic        m_sda_pipe[$];
    logic [15:0] m_scl_hist;
    logic [15:0] m_sda_hist;
    logic        m_scl_clean;
    logic        m_sda_clean;
    logic        m_rise;
    logic        m_fall;
    logic        m_start;
    logic        m_stop;
    logic        m_busy;
    logic        m_timeout;
    int          m_low_cycles;
    int          m_glitches;

    twi_line_filter #(
        .SYNC_STAGES   (SYNC_STAGES),
        .FILTER_LEN    (FILTER_LEN),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk_16mhz   (clk_16mhz),
        .rst         (rst),
        .scl_raw     (scl_raw),
        .sda_raw     (sda_raw),
        .scl_clean   (scl_clean),
        .sda_clean   (sda_clean),
        .scl_rise    (scl_rise),
        .scl_fall    (scl_fall),
        .start_det   (start_det),
        .stop_det    (stop_det),
        .bus_busy    (bus_busy),
        .bus_timeout (bus_timeout),
        .glitch_count(glitch_count)
    );

    // 16 MHz-ish system clock.
    initial begin
        clk_16mhz = 1'b0;
        forever #31 clk_16mhz = ~clk_16mhz;
    end

    function automatic logic [31:0] dutVec();
        return {16'b0, scl_clean, sda_clean, scl_rise, scl_fall, start_det, stop_det,
                bus_busy, bus_timeout, glitch_count};
    endfunction

    function automatic logic [31:0] modelVec();
        return {16'b0, m_scl_clean, m_sda_clean, m_rise, m_fall, m_start, m_stop,
                m_busy, m_timeout, 8'(m_glitches)};
    endfunction

    function automatic void modelReset();
        m_scl_pipe.delete();
        m_sda_pipe.delete();
        for (int i = 0; i < SYNC_STAGES; i++) begin
            m_scl_pipe.push_back(1'b1);
            m_sda_pipe.push_back(1'b1);
        end
        m_scl_hist   = '1;
        m_sda_hist   = '1;
        m_scl_clean  = 1'b1;
        m_sda_clean  = 1'b1;
        m_rise       = 1'b0;
        m_fall       = 1'b0;
        m_start      = 1'b0;
        m_stop       = 1'b0;
        m_busy       = 1'b0;
        m_timeout    = 1'b0;
        m_low_cycles = 0;
        m_glitches   = 0;
    endfunction

    // One clock edge of the model. A line takes a new level once its last
    // FILTER_LEN synchronized samples all disagree with the clean level; a
    // sample that matches clean right after a disagreeing one is a glitch.
    function automatic void modelEdge(input logic rs, input logic rd);
        logic s_scl, s_sda, f_scl, f_sda, g_scl, g_sda;
        s_scl = m_scl_pipe.pop_front();
        s_sda = m_sda_pipe.pop_front();
        m_scl_pipe.push_back(rs);
        m_sda_pipe.push_back(rd);
        g_scl = (s_scl == m_scl_clean) && (m_scl_hist[0] != m_scl_clean);
        g_sda = (s_sda == m_sda_clean) && (m_sda_hist[0] != m_sda_clean);
        m_scl_hist = {m_scl_hist[14:0], s_scl};
        m_sda_hist = {m_sda_hist[14:0], s_sda};
        f_scl = m_scl_clean ? ((m_scl_hist & FMASK) == 16'd0) : ((m_scl_hist & FMASK) == FMASK);
        f_sda = m_sda_clean ? ((m_sda_hist & FMASK) == 16'd0) : ((m_sda_hist & FMASK) == FMASK);
        m_rise    = f_scl && s_scl;
        m_fall    = f_scl && !s_scl;
        m_start   = f_sda && !s_sda && m_scl_clean && !f_scl;
        m_stop    = f_sda &&  s_sda && m_scl_clean && !f_scl;
        m_timeout = m_busy && !m_scl_clean && (m_low_cycles == TIMEOUT_CYCLES - 1);
        if (m_busy && !m_scl_clean && !m_timeout) m_low_cycles++;
        else m_low_cycles = 0;
        if (m_start) m_busy = 1'b1;
        else if (m_stop || m_timeout) m_busy = 1'b0;
        m_glitches = m_glitches + int'(g_scl) + int'(g_sda);
        if (m_glitches > 255) m_glitches = 255;
        if (f_scl) m_scl_clean = s_scl;
        if (f_sda) m_sda_clean = s_sda;
    endfunction

    // Counts and reports one comparison.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %h expected %h (cycle %0d)", tag, observed, expected, cycle);
        end
    endtask

    // Holds the raw pins for one clock edge and checks all outputs after it.
    task automatic applyStimulus(input logic scl_in, input logic sda_in);
        scl_raw = scl_in;
        sda_raw = sda_in;
        @(posedge clk_16mhz);
        modelEdge(scl_in, sda_in);
        #1;
        cycle++;
        checkOutput("outputs", dutVec(), modelVec());
        n_rise    += int'(scl_rise);
        n_fall    += int'(scl_fall);
        n_start   += int'(start_det);
        n_stop    += int'(stop_det);
        n_timeout += int'(bus_timeout);
        @(negedge clk_16mhz);
    endtask

    // Asserts reset between clock edges, checks it takes effect without a
    // clock, holds it a few cycles and releases it with idle pins.
    task automatic applyReset();
        #5;
        rst = 1'b1;
        #1;
        modelReset();
        checkOutput("reset_async", dutVec(), RESET_VEC);
        repeat (3) begin
            @(posedge clk_16mhz);
            #1;
            checkOutput("reset_hold", dutVec(), RESET_VEC);
        end
        @(negedge clk_16mhz);
        scl_raw = 1'b1;
        sda_raw = 1'b1;
        rst     = 1'b0;
    endtask

    function automatic void clearCounts();
        n_rise    = 0;
        n_fall    = 0;
        n_start   = 0;
        n_stop    = 0;
        n_timeout = 0;
    endfunction

    // Directed bus scenarios followed by random line noise.
    initial begin
        int         lat;
        int         fall_at;
        int         to_at;
        int         rate;
        logic       rs;
        logic       rd;
        logic       sda_bit;
        logic [7:0] byte_val;

        vectors     = 0;
        miscompares = 0;
        cycle       = 0;
        clearCounts();
        rst     = 1'b1;
        scl_raw = 1'b1;
        sda_raw = 1'b1;
        modelReset();
        #5;
        checkOutput("reset_state", dutVec(), RESET_VEC);
        @(negedge clk_16mhz);
        applyReset();

        // START from idle: sda_clean falls on the 6th edge with start_det.
        lat = -1;
        for (int i = 1; i <= 12; i++) begin
            applyStimulus(1'b1, 1'b0);
            if (lat < 0 && !sda_clean) begin
                lat = i;
                checkOutput("start_pulse", 32'(start_det), 32'd1);
                checkOutput("busy_on_start", 32'(bus_busy), 32'd1);
            end
        end
        checkOutput("start_latency", 32'(lat), 32'd6);
        repeat (10) applyStimulus(1'b1, 1'b1);
        checkOutput("busy_after_stop", 32'(bus_busy), 32'd0);

        // Both lines toggle together: edge pulses only, no START/STOP.
        clearCounts();
        repeat (10) applyStimulus(1'b0, 1'b0);
        repeat (10) applyStimulus(1'b1, 1'b1);
        checkOutput("simul_start", 32'(n_start), 32'd0);
        checkOutput("simul_stop", 32'(n_stop), 32'd0);
        checkOutput("simul_fall", 32'(n_fall), 32'd1);
        checkOutput("simul_rise", 32'(n_rise), 32'd1);

        // Full byte: START, 8 SCL clocks of 160 cycles, ack clock, STOP.
        clearCounts();
        byte_val = 8'($urandom);
        sda_bit  = 1'b0;
        repeat (10) applyStimulus(1'b1, 1'b0);
        for (int b = 0; b < 8; b++) begin
            repeat (40) applyStimulus(1'b0, sda_bit);
            sda_bit = byte_val[7-b];
            repeat (40) applyStimulus(1'b0, sda_bit);
            repeat (80) applyStimulus(1'b1, sda_bit);
        end
        repeat (40) applyStimulus(1'b0, sda_bit);
        repeat (40) applyStimulus(1'b0, 1'b0);
        repeat (80) applyStimulus(1'b1, 1'b0);
        repeat (20) applyStimulus(1'b1, 1'b1);
        checkOutput("byte_rise", 32'(n_rise), 32'd9);
        checkOutput("byte_fall", 32'(n_fall), 32'd9);
        checkOutput("byte_start", 32'(n_start), 32'd1);
        checkOutput("byte_stop", 32'(n_stop), 32'd1);
        checkOutput("byte_busy_end", 32'(bus_busy), 32'd0);

        // Stuck-low SCL after START: exactly one timeout, 40000 cycles on.
        clearCounts();
        fall_at = -1;
        to_at   = -1;
        repeat (10) applyStimulus(1'b1, 1'b0);
        for (int i = 0; i < TIMEOUT_CYCLES + 200; i++) begin
            applyStimulus(1'b0, 1'b0);
            if (scl_fall && fall_at < 0) fall_at = cycle;
            if (bus_timeout && to_at < 0) to_at = cycle;
        end
        checkOutput("timeout_delay", 32'(to_at - fall_at), 32'(TIMEOUT_CYCLES));
        checkOutput("timeout_count", 32'(n_timeout), 32'd1);
        checkOutput("timeout_busy", 32'(bus_busy), 32'd0);
        repeat (10) applyStimulus(1'b1, 1'b0);
        repeat (10) applyStimulus(1'b1, 1'b1);

        // Random noise on both lines with varying toggle rates.
        applyReset();
        rs = 1'b1;
        rd = 1'b1;
        for (int blk = 0; blk < 6; blk++) begin
            rate = int'($urandom_range(1, 6));
            for (int i = 0; i < 500; i++) begin
                if ($urandom_range(0, rate) == 0) rs = ~rs;
                if ($urandom_range(0, rate) == 0) rd = ~rd;
                applyStimulus(rs, rd);
            end
        end

        // Reset in the middle of a byte aborts without STOP or timeout.
        applyReset();
        clearCounts();
        repeat (10) applyStimulus(1'b1, 1'b0);
        repeat (80) applyStimulus(1'b0, 1'b0);
        repeat (80) applyStimulus(1'b1, 1'b1);
        repeat (30) applyStimulus(1'b0, 1'b1);
        checkOutput("busy_mid_byte", 32'(bus_busy), 32'd1);
        scl_raw = 1'b0;
        sda_raw = 1'b0;
        applyReset();
        checkOutput("abort_no_stop", 32'(n_stop), 32'd0);
        repeat (10) applyStimulus(1'b1, 1'b1);

        // Short SDA dips are rejected and counted, saturating at 255.
        applyReset();
        clearCounts();
        repeat (5) applyStimulus(1'b1, 1'b1);
        for (int k = 0; k < 300; k++) begin
            repeat (3) applyStimulus(1'b1, 1'b0);
            repeat (5) applyStimulus(1'b1, 1'b1);
            if (k == 0) checkOutput("glitch_first", 32'(glitch_count), 32'd1);
        end
        checkOutput("glitch_saturate", 32'(glitch_count), 32'd255);
        checkOutput("glitch_sda_held", 32'(sda_clean), 32'd1);
        checkOutput("glitch_no_start", 32'(n_start), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
